// File: rtl/register_file_sb.sv
// Parametrised 2-read/1-write register file with an integrated writeback scoreboard.
// Decode reads operands and busy flags combinationally; writeback clears busy bits that issue sets.
module register_file_sb #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS),
  localparam int CW       = $clog2(NREGS + 1)
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            ISSUE_EN,
  input  logic [AW-1:0]   ISSUE_RD,
  output logic [CW-1:0]   PEND_CNT
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             we_ok;
  logic             iss_ok;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [NREGS-1:0] b);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NREGS; i++) n = n + CW'(b[i]);
    return n;
  endfunction

  assign we_ok  = WE3 && addr_ok(A3);
  assign iss_ok = ISSUE_EN && addr_ok(ISSUE_RD);

  function automatic logic fwd_hit(input logic [AW-1:0] a);
    return (BYPASS != 0) && we_ok && (A3 == a);
  endfunction

  function automatic logic [XLEN-1:0] rd_data(input logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    d = '0;
    if (addr_ok(a)) begin
      if (fwd_hit(a)) d = WD3;
      else            d = regs[a];
    end
    return d;
  endfunction

  // A forwarded writeback makes the operand usable now, so it hides the busy bit.
  function automatic logic busy_rd(input logic [AW-1:0] a);
    logic b;
    b = 1'b0;
    if (addr_ok(a) && !fwd_hit(a)) b = busy[a];
    return b;
  endfunction

  always_comb begin
    RD1   = rd_data(A1);
    RD2   = rd_data(A2);
    BUSY1 = busy_rd(A1);
    BUSY2 = busy_rd(A2);
  end

  // Issue is applied after writeback so a same-cycle set on the same register wins.
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < NREGS; r++) begin
      if (we_ok && (int'(A3) == r))        busy_nxt[r] = 1'b0;
      if (iss_ok && (int'(ISSUE_RD) == r)) busy_nxt[r] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      busy     <= '0;
      PEND_CNT <= '0;
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      busy     <= busy_nxt;
      PEND_CNT <= popcount(busy_nxt);
      if (we_ok) regs[A3] <= WD3;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two configurations (24 regs with bypass, 32 regs without)
// share one stimulus stream and are compared against an array-based reference model.
module tb_register_file_sb;

  logic        CLK;
  logic        CLR;
  logic        WE3;
  logic        ISSUE_EN;
  logic [4:0]  A1, A2, A3, ISSUE_RD;
  logic [31:0] WD3;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy1_a, busy2_a, busy1_b, busy2_b;
  logic [4:0]  pend_a;
  logic [5:0]  pend_b;

  int checks = 0;
  int errors = 0;

  int NR [2] = '{24, 32};
  int BP [2] = '{1, 0};
  logic [31:0] m_reg  [2][64];
  bit          m_busy [2][64];

  register_file_sb #(.XLEN(32), .NREGS(24), .ZERO_REG(1), .BYPASS(1)) u_a (
    .CLK(CLK), .CLR(CLR), .A1(A1), .A2(A2), .RD1(rd1_a), .RD2(rd2_a),
    .BUSY1(busy1_a), .BUSY2(busy2_a), .WE3(WE3), .A3(A3), .WD3(WD3),
    .ISSUE_EN(ISSUE_EN), .ISSUE_RD(ISSUE_RD), .PEND_CNT(pend_a)
  );

  register_file_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0)) u_b (
    .CLK(CLK), .CLR(CLR), .A1(A1), .A2(A2), .RD1(rd1_b), .RD2(rd2_b),
    .BUSY1(busy1_b), .BUSY2(busy2_b), .WE3(WE3), .A3(A3), .WD3(WD3),
    .ISSUE_EN(ISSUE_EN), .ISSUE_RD(ISSUE_RD), .PEND_CNT(pend_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit valid(input int k, input logic [4:0] a);
    return (int'(a) < NR[k]) && (a != 5'd0);
  endfunction

  function automatic bit fwd(input int k, input logic [4:0] a);
    return (BP[k] == 1) && WE3 && valid(k, A3) && (A3 == a);
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
    if (!valid(k, a)) return 32'd0;
    if (fwd(k, a))    return WD3;
    return m_reg[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [4:0] a);
    if (!valid(k, a) || fwd(k, a)) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic int exp_pend(input int k);
    int n = 0;
    for (int r = 0; r < 64; r++) n += int'(m_busy[k][r]);
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 64; r++) begin
        m_reg[k][r]  = 32'd0;
        m_busy[k][r] = 1'b0;
      end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (WE3 && valid(k, A3)) begin
        m_reg[k][A3]  = WD3;
        m_busy[k][A3] = 1'b0;
      end
      if (ISSUE_EN && valid(k, ISSUE_RD)) m_busy[k][ISSUE_RD] = 1'b1;
    end
  endtask

  task automatic idle();
    WE3 = 1'b0; A3 = 5'd0; WD3 = 32'd0;
    ISSUE_EN = 1'b0; ISSUE_RD = 5'd0;
  endtask

  // Called at edge+1: settle inputs, compare every output against the model.
  task automatic look();
    #2;
    check_val("rd1_a", rd1_a, exp_rd(0, A1));
    check_val("rd2_a", rd2_a, exp_rd(0, A2));
    check_val("busy1_a", busy1_a, exp_busy(0, A1));
    check_val("busy2_a", busy2_a, exp_busy(0, A2));
    check_val("pend_a", pend_a, exp_pend(0));
    check_val("rd1_b", rd1_b, exp_rd(1, A1));
    check_val("rd2_b", rd2_b, exp_rd(1, A2));
    check_val("busy1_b", busy1_b, exp_busy(1, A1));
    check_val("busy2_b", busy2_b, exp_busy(1, A2));
    check_val("pend_b", pend_b, exp_pend(1));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (CLR) model_edge();
    #1;
  endtask

  initial begin
    CLR = 1'b0;
    A1 = 5'd0; A2 = 5'd0;
    idle();
    model_reset();
    look();
    CLR = 1'b1;
    tick();

    // Reset mid-run is immediate and discards same-cycle activity.
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h1234; A1 = 5'd5;
    tick();
    idle(); A1 = 5'd5;
    look();
    check_val("r5_written", rd1_a, 32'h1234);
    CLR = 1'b0;
    model_reset();
    #1;
    check_val("rst_rd1", rd1_a, 32'd0);
    check_val("rst_busy1", busy1_a, 1'b0);
    check_val("rst_pend", pend_a, 5'd0);
    WE3 = 1'b1; A3 = 5'd6; WD3 = 32'h5555; ISSUE_EN = 1'b1; ISSUE_RD = 5'd6;
    @(posedge CLK); #1;
    CLR = 1'b1;
    idle(); A1 = 5'd6;
    look();
    check_val("rst_drop_rd", rd1_a, 32'd0);
    check_val("rst_drop_busy", busy1_a, 1'b0);
    tick();

    // Hardwired zero register.
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFF_FFFF; ISSUE_EN = 1'b1; ISSUE_RD = 5'd0; A1 = 5'd0;
    look();
    tick();
    idle(); A1 = 5'd0;
    look();
    check_val("zero_rd", rd1_a, 32'd0);
    check_val("zero_busy", busy1_a, 1'b0);
    check_val("zero_pend", pend_a, 5'd0);
    tick();

    // Same-cycle bypass vs one-cycle visibility.
    WE3 = 1'b1; A3 = 5'd1; WD3 = 32'h0ABC_DEF0; A1 = 5'd1;
    look();
    check_val("byp_a", rd1_a, 32'h0ABC_DEF0);
    check_val("nobyp_old_b", rd1_b, 32'd0);
    tick();
    idle(); A1 = 5'd1;
    look();
    check_val("nobyp_new_b", rd1_b, 32'h0ABC_DEF0);
    tick();

    // Scoreboard set and bypassed clear.
    ISSUE_EN = 1'b1; ISSUE_RD = 5'd4;
    look();
    tick();
    idle(); A2 = 5'd4;
    look();
    check_val("sb_busy", busy2_a, 1'b1);
    check_val("sb_pend1", pend_a, 5'd1);
    WE3 = 1'b1; A3 = 5'd4; WD3 = 32'hFFFF_FFFF;
    look();
    check_val("sb_wb_busy", busy2_a, 1'b0);
    check_val("sb_wb_rd", rd2_a, 32'hFFFF_FFFF);
    check_val("sb_wb_busy_b", busy2_b, 1'b1);
    tick();
    idle();
    look();
    check_val("sb_pend0", pend_a, 5'd0);
    tick();

    // Simultaneous issue and writeback.
    ISSUE_EN = 1'b1; ISSUE_RD = 5'd7;
    tick();
    ISSUE_EN = 1'b1; ISSUE_RD = 5'd7; WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h77; A1 = 5'd7;
    look();
    tick();
    idle(); A1 = 5'd7;
    look();
    check_val("sim_busy", busy1_a, 1'b1);
    check_val("sim_data", rd1_a, 32'h77);
    check_val("sim_pend", pend_a, 5'd1);
    ISSUE_EN = 1'b1; ISSUE_RD = 5'd8; WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h78;
    tick();
    idle(); A1 = 5'd7; A2 = 5'd8;
    look();
    check_val("mix_pend", pend_a, 5'd1);
    check_val("mix_r8", busy2_a, 1'b1);
    check_val("mix_r7", busy1_a, 1'b0);
    tick();

    // Out-of-range addresses on the 24-register instance.
    A1 = 5'd25; WE3 = 1'b1; A3 = 5'd30; WD3 = 32'hDEAD_BEEF; ISSUE_EN = 1'b1; ISSUE_RD = 5'd31;
    look();
    check_val("oor_rd", rd1_a, 32'd0);
    check_val("oor_busy", busy1_a, 1'b0);
    tick();
    idle(); A1 = 5'd25;
    look();
    check_val("oor_pend", pend_a, 5'd1);
    for (int i = 1; i < 24; i++) begin
      ISSUE_EN = 1'b1; ISSUE_RD = 5'(i);
      tick();
    end
    idle();
    look();
    check_val("full_pend", pend_a, 5'd23);
    for (int i = 24; i < 32; i++) begin
      ISSUE_EN = 1'b1; ISSUE_RD = 5'(i);
      tick();
    end
    idle();
    look();
    check_val("full_cap", pend_a, 5'd23);

    CLR = 1'b0;
    model_reset();
    #1;
    CLR = 1'b1;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      WE3      = 1'($urandom_range(0, 1));
      A3       = 5'($urandom_range(0, 31));
      WD3      = $urandom;
      ISSUE_EN = 1'($urandom_range(0, 1));
      ISSUE_RD = 5'($urandom_range(0, 31));
      A1       = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
      A2       = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
      look();
      tick();
    end
    idle();
    look();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised successor to the CPU's 2-read/1-write register file. It adds configurable width and depth, an optional hardwired-zero register and optional write-to-read bypass. It also carries an integrated scoreboard that tracks pending writebacks, so the decode stage can detect RAW hazards. The block sits between decode (reads, issue) and writeback (write).

Parameters:
XLEN, 32, data width of each register in bits.
NREGS, 32, number of architectural registers (2..64, need not be a power of two).
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never marked busy.
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports and clears the busy indication on those ports.
AW (localparam), clog2(NREGS), address width.
CW (localparam), clog2(NREGS+1), pending-count width.

Ports:
CLK  input  1  clock, all state updates on rising edge.
CLR  input  1  asynchronous active-low reset (0 = clear).
A1  input  AW  read address, port 1.
A2  input  AW  read address, port 2.
RD1  output  XLEN  read data, port 1 (combinational).
RD2  output  XLEN  read data, port 2 (combinational).
BUSY1  output  1  register at A1 has a pending writeback.
BUSY2  output  1  register at A2 has a pending writeback.
WE3  input  1  writeback enable.
A3  input  AW  writeback address.
WD3  input  XLEN  writeback data.
ISSUE_EN  input  1  an instruction with destination ISSUE_RD issues this cycle.
ISSUE_RD  input  AW  destination register of the issuing instruction.
PEND_CNT  output  CW  number of registers currently marked busy (registered).

Behaviour:
- Reset (CLR=0, asynchronous):
  - all registers = 0, all busy bits = 0, PEND_CNT = 0;
  - outputs follow combinationally from the cleared state;
  - reset mid-operation discards any pending issue or write in that cycle.
- Write: at posedge, if WE3=1 and A3 is valid, reg[A3] <= WD3.
  - A3 is valid when A3 < NREGS and not (ZERO_REG=1 and A3=0).
  - Invalid A3: write ignored, no state change.
- Read, combinational, same rule per port:
  - Address >= NREGS: RD = 0.
  - ZERO_REG=1 and address=0: RD = 0.
  - BYPASS=1, WE3=1, A3 valid and A3 equals the read address: RD = WD3.
  - Otherwise RD = reg[address].
  - BYPASS=0: a read of a register written this cycle returns the old value; the new value appears the cycle after the edge.
- Scoreboard, per valid register r, updated at posedge:
  - Set when ISSUE_EN=1 and ISSUE_RD=r.
  - Clear when WE3=1 and A3=r.
  - Set and clear on the same r in the same cycle: set wins (newer producer outstanding).
  - Invalid ISSUE_RD (out of range, or 0 with ZERO_REG=1): ignored.
  - WE3 to a non-busy register: legal; data is written and the busy bit stays 0.
  - ISSUE_EN to an already-busy register: legal; the bit stays 1 and is cleared by the next writeback to that register (single outstanding producer per register is a system rule).
- BUSY1/BUSY2 = busy[addr], forced 0 when:
  - the address is invalid, or
  - BYPASS=1 and a valid WE3 to the same address occurs this cycle.
  - Consequence: with BYPASS=1, data is usable in the writeback cycle itself.
- PEND_CNT: registered population count of the busy bits.
  - Changes by -1, 0 or +1 per cycle.
  - Never exceeds NREGS-ZERO_REG.
  - Issue and writeback to different registers in the same cycle: net 0.
- Latency:
  - Writes visible on reads 0 cycles after the edge with BYPASS=1, otherwise 1 cycle.
  - Busy set visible the cycle after the issue edge.

Test Plan:
1. Reset: CLR=0 mid-run after writing r5=32'h1234 -> RD1(A1=5)=0, BUSY1=0, PEND_CNT=0 immediately, without waiting for a clock edge.
2. Zero register: WE3=1, A3=0, WD3=32'hFFFFFFFF, ISSUE_EN=1, ISSUE_RD=0 -> RD1(A1=0)=0, BUSY1=0, PEND_CNT=0 after the edge.
3. Write and bypass: WE3=1, A3=1, WD3=32'h0ABCDEF0, A1=1 -> with BYPASS=1, RD1=32'h0ABCDEF0 in the same cycle; with BYPASS=0, RD1 shows the old value until the edge, then 32'h0ABCDEF0.
4. Scoreboard: issue to r4 -> next cycle BUSY2(A2=4)=1, PEND_CNT=1. Writeback WE3=1, A3=4, WD3=32'hFFFFFFFF -> BUSY2=0 and RD2=32'hFFFFFFFF in the same cycle (BYPASS=1), PEND_CNT=0 after the edge.
5. Simultaneous events: r7 busy, then ISSUE_RD=7 and WE3 to A3=7 in the same cycle -> r7 data updated, BUSY stays 1, PEND_CNT unchanged. Issue r8 plus writeback r7 in one cycle -> PEND_CNT unchanged, r8 busy, r7 clear.
6. Boundaries: NREGS=24, then A1=25, WE3 to A3=30, and issue to 31 -> RD1=0, BUSY1=0, no state change. Issue all 23 valid registers -> PEND_CNT=23.
